cam_tag_ctrl: RTL

Sequencing controller for the 16-entry × 6-bit tag CAM in the cache tag path. Accepts one tag lookup at a time over a valid/ready handshake and drives the CAM's match argument. It masks and priority-encodes the returned match bits against its own per-entry valid vector. On a miss it allocates a victim entry (first invalid, else round-robin) and writes the tag through the CAM's active-low write port. It then returns hit/miss and the entry index to the cache controller.

---
 rtl/cam_tag_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cam_tag_ctrl.sv
// Lookup/allocate sequencer for a 16-entry x 6-bit tag CAM with valid masking and victim selection.
// Optional hit/miss statistics counters are enabled by defining CAM_TAG_CTRL_STATS_EN.
`timescale 1ns/1ps

module cam_tag_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [5:0]  req_tag,
    input  logic        flush,
    output logic        ready,
    output logic        rsp_valid,
    output logic        rsp_hit,
    output logic [3:0]  rsp_idx,
    output logic        rsp_multi,
    output logic        cam_we_n,
    output logic        cam_rd_n,
    output logic [5:0]  cam_din,
    output logic [5:0]  cam_argin,
    output logic [3:0]  cam_addrs,
    input  logic [15:0] cam_mbits
`ifdef CAM_TAG_CTRL_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_ALLOC  = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] valid_q;
    logic [3:0]  rr_q;
    logic [5:0]  tag_q;
    logic [3:0]  victim_q;

    logic        rsp_valid_q;
    logic        rsp_hit_q;
    logic [3:0]  rsp_idx_q;
    logic        rsp_multi_q;
    logic        cam_we_n_q;
    logic [5:0]  cam_din_q;
    logic [5:0]  cam_argin_q;
    logic [3:0]  cam_addrs_q;

`ifdef CAM_TAG_CTRL_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
`endif

    // The CAM's raw match bits are meaningless for entries never written (power-up 6'h3f).
    logic [15:0] hit_vec;
    logic        hit_any;
    logic        hit_multi;
    logic [3:0]  hit_idx;
    logic        free_any;
    logic [3:0]  free_idx;
    logic [3:0]  victim_d;

    assign hit_vec   = cam_mbits & valid_q;
    assign hit_any   = |hit_vec;
    assign hit_multi = |(hit_vec & (hit_vec - 16'd1));
    assign free_any  = ~&valid_q;
    assign victim_d  = free_any ? free_idx : rr_q;

    always_comb begin
        hit_idx  = 4'd0;
        free_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_idx = 4'(i);
            end
            if (!valid_q[i]) begin
                free_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= 16'd0;
            rr_q        <= 4'd0;
            tag_q       <= 6'd0;
            victim_q    <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= 4'd0;
            rsp_multi_q <= 1'b0;
            cam_we_n_q  <= 1'b1;
            cam_din_q   <= 6'd0;
            cam_argin_q <= 6'd0;
            cam_addrs_q <= 4'd0;
`ifdef CAM_TAG_CTRL_STATS_EN
            hit_cnt_q   <= 16'd0;
            miss_cnt_q  <= 16'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (flush) begin
                        valid_q <= 16'd0;
                        rr_q    <= 4'd0;
`ifdef CAM_TAG_CTRL_STATS_EN
                        hit_cnt_q  <= 16'd0;
                        miss_cnt_q <= 16'd0;
`endif
                    end else if (req) begin
                        tag_q       <= req_tag;
                        cam_argin_q <= req_tag;
                        state_q     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_any) begin
                        rsp_idx_q   <= hit_idx;
                        rsp_hit_q   <= 1'b1;
                        rsp_multi_q <= hit_multi;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        // Round-robin pointer only advances when every entry is occupied.
                        if (!free_any) begin
                            rr_q <= rr_q + 4'd1;
                        end
                        victim_q    <= victim_d;
                        cam_addrs_q <= victim_d;
                        cam_din_q   <= tag_q;
                        state_q     <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    cam_we_n_q <= 1'b0;
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    cam_we_n_q        <= 1'b1;
                    valid_q[victim_q] <= 1'b1;
                    rsp_idx_q         <= victim_q;
                    rsp_hit_q         <= 1'b0;
                    rsp_multi_q       <= 1'b0;
                    rsp_valid_q       <= 1'b1;
                    state_q           <= S_DONE;
                end
                S_DONE: begin
                    rsp_valid_q <= 1'b0;
`ifdef CAM_TAG_CTRL_STATS_EN
                    if (rsp_hit_q) begin
                        if (hit_cnt_q != 16'hffff) begin
                            hit_cnt_q <= hit_cnt_q + 16'd1;
                        end
                    end else begin
                        if (miss_cnt_q != 16'hffff) begin
                            miss_cnt_q <= miss_cnt_q + 16'd1;
                        end
                    end
`endif
                    state_q <= S_IDLE;
                end
                default: begin
                    cam_we_n_q  <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == S_IDLE) && !flush;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_multi = rsp_multi_q;
    assign cam_we_n  = cam_we_n_q;
    assign cam_rd_n  = 1'b1;
    assign cam_din   = cam_din_q;
    assign cam_argin = cam_argin_q;
    assign cam_addrs = cam_addrs_q;

`ifdef CAM_TAG_CTRL_STATS_EN
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
